// File: rtl/codec_cfg_pkg.sv
// Shared types and WM8731 register-table constants for the codec configuration sequencer.
package codec_cfg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_GO,
        S_GAP,
        S_RELEASE,
        S_NEXT,
        S_DONE,
        S_ERR
    } state_t;

    localparam int TABLE_LEN = 10;

    localparam logic [6:0] R_LLINE   = 7'h00;
    localparam logic [6:0] R_RLINE   = 7'h01;
    localparam logic [6:0] R_LHP     = 7'h02;
    localparam logic [6:0] R_RHP     = 7'h03;
    localparam logic [6:0] R_ANALOG  = 7'h04;
    localparam logic [6:0] R_DIGITAL = 7'h05;
    localparam logic [6:0] R_POWER   = 7'h06;
    localparam logic [6:0] R_IFACE   = 7'h07;
    localparam logic [6:0] R_SAMPLE  = 7'h08;
    localparam logic [6:0] R_ACTIVE  = 7'h09;

    localparam logic [8:0] VAL_LINE        = 9'h017;
    localparam logic [8:0] VAL_ANALOG_MIC  = 9'h014;
    localparam logic [8:0] VAL_ANALOG_LINE = 9'h012;
    localparam logic [8:0] VAL_DIGITAL     = 9'h000;
    localparam logic [8:0] VAL_POWER       = 9'h000;
    localparam logic [8:0] VAL_IFACE       = 9'h001;
    localparam logic [8:0] VAL_SAMPLE      = 9'h000;
    localparam logic [8:0] VAL_ACTIVE      = 9'h001;

    // Headphone and analogue-path values depend on live volume / input selection.
    function automatic logic [8:0] reg_value(input logic [6:0] addr,
                                             input logic [6:0] vol,
                                             input logic       mic);
        logic [8:0] val;
        val = 9'h000;
        case (addr)
            R_LLINE, R_RLINE: val = VAL_LINE;
            R_LHP, R_RHP:     val = {2'b01, vol};
            R_ANALOG:         val = mic ? VAL_ANALOG_MIC : VAL_ANALOG_LINE;
            R_DIGITAL:        val = VAL_DIGITAL;
            R_POWER:          val = VAL_POWER;
            R_IFACE:          val = VAL_IFACE;
            R_SAMPLE:         val = VAL_SAMPLE;
            R_ACTIVE:         val = VAL_ACTIVE;
            default:          val = 9'h000;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/cfg_timeout_ctr.sv
// Loadable down-counter; expired is high once the count has reached zero.
module cfg_timeout_ctr #(
    parameter int WIDTH = 13
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             expired
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (en && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign expired = (count_reg == '0);

endmodule

// File: rtl/codec_config_sequencer.sv
// Programs the WM8731 register table over i2c after reset, then rewrites R4 or R2/R3
// on input-select and volume changes. Define CFG_VOL_DOWN_EN to add the vol_down input.
module codec_config_sequencer #(
    parameter logic [7:0] DEV_ADDR       = 8'h34,
    parameter logic [6:0] VOL_MIN        = 7'h30,
    parameter logic [6:0] VOL_MAX        = 7'h7F,
    parameter logic [6:0] VOL_INIT       = 7'h79,
    parameter logic [6:0] VOL_STEP       = 7'h04,
    parameter int         TIMEOUT_CYCLES = 4096,
    parameter int         MAX_RETRY      = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sel_mic,
    input  logic        vol_up,
`ifdef CFG_VOL_DOWN_EN
    input  logic        vol_down,
`endif
    input  logic        i2c_end_tr,
    output logic        i2c_go,
    output logic [23:0] i2c_data,
    output logic        busy,
    output logic        cfg_done,
    output logic        error,
    output logic [6:0]  volume
);
    import codec_cfg_pkg::*;

    localparam int CTR_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    state_t             state_reg, state_next;
    logic [3:0]         index_reg, index_next;
    logic [RETRY_W-1:0] retry_reg, retry_next;
    logic [23:0]        i2c_data_reg;
    logic               cfg_done_reg;
    logic [6:0]         volume_reg, volume_next;
    logic [1:0]         sync_reg;
    logic               mic_prev_reg, mic_pend_reg, vol_pend_reg;

    logic       load_word, ctr_load, ctr_expired;
    logic       take_mic, take_vol, finish_init;
    logic       mic_sync, mic_change, vol_req;
    logic [6:0] reg_addr;
    logic [7:0] vol_sum;
    logic [6:0] vol_up_val;

    assign mic_sync   = sync_reg[1];
    assign mic_change = mic_sync ^ mic_prev_reg;
    assign reg_addr   = {3'b000, index_reg};

    assign vol_sum    = {1'b0, volume_reg} + {1'b0, VOL_STEP};
    assign vol_up_val = (vol_sum > {1'b0, VOL_MAX}) ? VOL_MIN : vol_sum[6:0];

`ifdef CFG_VOL_DOWN_EN
    logic       vol_inc, vol_dec;
    logic [6:0] vol_dn_val;
    assign vol_inc    = vol_up & ~vol_down;
    assign vol_dec    = vol_down & ~vol_up;
    assign vol_dn_val = ({1'b0, volume_reg} < ({1'b0, VOL_MIN} + {1'b0, VOL_STEP}))
                        ? VOL_MAX : (volume_reg - VOL_STEP);
    assign vol_req    = vol_inc | vol_dec;
    assign volume_next = vol_inc ? vol_up_val : (vol_dec ? vol_dn_val : volume_reg);
`else
    assign vol_req     = vol_up;
    assign volume_next = vol_up ? vol_up_val : volume_reg;
`endif

    cfg_timeout_ctr #(
        .WIDTH(CTR_W)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .load    (ctr_load),
        .load_val(CTR_W'(TIMEOUT_CYCLES - 1)),
        .en      (state_reg == S_GO),
        .expired (ctr_expired)
    );

    always_comb begin
        state_next  = state_reg;
        index_next  = index_reg;
        retry_next  = retry_reg;
        load_word   = 1'b0;
        ctr_load    = 1'b0;
        take_mic    = 1'b0;
        take_vol    = 1'b0;
        finish_init = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (mic_pend_reg) begin
                    take_mic   = 1'b1;
                    index_next = R_ANALOG[3:0];
                    state_next = S_LOAD;
                end else if (vol_pend_reg) begin
                    take_vol   = 1'b1;
                    index_next = R_LHP[3:0];
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                load_word  = 1'b1;
                ctr_load   = 1'b1;
                retry_next = '0;
                // never raise a new request while the previous ack is still high
                if (!i2c_end_tr) state_next = S_GO;
            end
            S_GO: begin
                if (i2c_end_tr) begin
                    state_next = S_RELEASE;
                end else if (ctr_expired) begin
                    if (retry_reg == RETRY_W'(MAX_RETRY)) begin
                        state_next = S_ERR;
                    end else begin
                        retry_next = retry_reg + 1'b1;
                        state_next = S_GAP;
                    end
                end
            end
            S_GAP: begin
                ctr_load = 1'b1;
                if (!i2c_end_tr) state_next = S_GO;
            end
            S_RELEASE: begin
                if (!i2c_end_tr) state_next = S_NEXT;
            end
            S_NEXT: begin
                if (!cfg_done_reg) begin
                    if (index_reg == 4'(TABLE_LEN - 1)) begin
                        state_next = S_DONE;
                    end else begin
                        index_next = index_reg + 4'd1;
                        state_next = S_LOAD;
                    end
                end else if (index_reg == R_LHP[3:0]) begin
                    index_next = R_RHP[3:0];
                    state_next = S_LOAD;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_DONE: begin
                finish_init = 1'b1;
                state_next  = S_IDLE;
            end
            S_ERR: begin
                state_next = S_ERR;
            end
            default: begin
                state_next = S_ERR;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= S_LOAD;
            index_reg    <= '0;
            retry_reg    <= '0;
            i2c_data_reg <= '0;
            cfg_done_reg <= 1'b0;
            volume_reg   <= VOL_INIT;
            sync_reg     <= '0;
            mic_prev_reg <= 1'b0;
            mic_pend_reg <= 1'b0;
            vol_pend_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            index_reg    <= index_next;
            retry_reg    <= retry_next;
            volume_reg   <= volume_next;
            sync_reg     <= {sync_reg[0], sel_mic};
            mic_prev_reg <= mic_sync;
            if (load_word) begin
                i2c_data_reg <= {DEV_ADDR, reg_addr, reg_value(reg_addr, volume_reg, mic_sync)};
            end
            if (finish_init) cfg_done_reg <= 1'b1;
            // a new request in the same cycle as its clear wins, so nothing is dropped
            if (mic_change)                  mic_pend_reg <= 1'b1;
            else if (take_mic || finish_init) mic_pend_reg <= 1'b0;
            if (vol_req)                     vol_pend_reg <= 1'b1;
            else if (take_vol || finish_init) vol_pend_reg <= 1'b0;
        end
    end

    assign i2c_go   = (state_reg == S_GO);
    assign i2c_data = i2c_data_reg;
    assign busy     = (state_reg != S_IDLE) || mic_pend_reg || vol_pend_reg;
    assign cfg_done = cfg_done_reg;
    assign error    = (state_reg == S_ERR);
    assign volume   = volume_reg;

endmodule

// File: tb/tb_codec_config_sequencer.sv
// Directed bench for codec_config_sequencer with a simple i2c responder model.
module tb_codec_config_sequencer;

    localparam int ACK_DELAY = 20;
    localparam int GAP_EXP   = 4097;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        sel_mic = 1'b0;
    logic        vol_up = 1'b0;
`ifdef CFG_VOL_DOWN_EN
    logic        vol_down = 1'b0;
`endif
    logic        i2c_end_tr = 1'b0;
    logic        i2c_go;
    logic [23:0] i2c_data;
    logic        busy, cfg_done, error;
    logic [6:0]  volume;

    int          checks = 0;
    int          fails = 0;
    int          cyc = 0;
    int          ack_cnt = 0;
    int          go_rise_bad = 0;
    logic        go_prev = 1'b0;
    logic        ack_en = 1'b1;
    logic [23:0] word_q[$];
    int          rise_q[$];

    codec_config_sequencer dut (
        .clock     (clock),
        .reset     (reset),
        .sel_mic   (sel_mic),
        .vol_up    (vol_up),
`ifdef CFG_VOL_DOWN_EN
        .vol_down  (vol_down),
`endif
        .i2c_end_tr(i2c_end_tr),
        .i2c_go    (i2c_go),
        .i2c_data  (i2c_data),
        .busy      (busy),
        .cfg_done  (cfg_done),
        .error     (error),
        .volume    (volume)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // i2c responder: logs each request, acks ACK_DELAY cycles into it, drops ack when go drops
    always @(negedge clock) begin
        if (reset) begin
            i2c_end_tr = 1'b0;
            ack_cnt    = 0;
            go_prev    = 1'b0;
        end else begin
            if (i2c_go && !go_prev) begin
                if (i2c_end_tr) go_rise_bad++;
                word_q.push_back(i2c_data);
                rise_q.push_back(cyc);
                $display("[cycle %0d] i2c word %06h", cyc, i2c_data);
            end
            go_prev = i2c_go;
            if (i2c_go) begin
                if (ack_en && ack_cnt < ACK_DELAY) ack_cnt++;
                if (ack_en && ack_cnt >= ACK_DELAY) i2c_end_tr = 1'b1;
            end else begin
                i2c_end_tr = 1'b0;
                ack_cnt    = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    initial begin
        int n;

        // reset state
        tick();
        tick();
        check("rst_go", i2c_go, 1'b0);
        check("rst_data", i2c_data, 24'h0);
        check("rst_busy", busy, 1'b1);
        check("rst_cfg_done", cfg_done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_volume", volume, 7'h79);

        // initial table
        reset = 1'b0;
        n = 0;
        while (cfg_done !== 1'b1 && n < 2000) begin tick(); n++; end
        check("init_cfg_done", cfg_done, 1'b1);
        check("init_count", word_q.size(), 10);
        check("init_w0", word_q[0], 24'h340017);
        check("init_w2", word_q[2], 24'h3404F9);
        check("init_w4", word_q[4], 24'h340812);
        check("init_w9", word_q[9], 24'h341201);
        check("init_busy", busy, 1'b0);

        // input select change
        word_q.delete();
        sel_mic = 1'b1;
        n = 0;
        while (busy !== 1'b1 && n < 10) begin tick(); n++; end
        check("mic_busy_rise", busy, 1'b1);
        n = 0;
        while (busy !== 1'b0 && n < 300) begin tick(); n++; end
        check("mic_busy_fall", busy, 1'b0);
        check("mic_count", word_q.size(), 1);
        check("mic_w0", word_q[0], 24'h340814);

        // volume up to 0x7C (wraps once on the way)
        for (int i = 0; i < 21; i++) begin
            vol_up = 1'b1;
            tick();
        end
        vol_up = 1'b0;
        check("vol_7c", volume, 7'h7C);
        n = 0;
        while (busy !== 1'b0 && n < 500) begin tick(); n++; end
        check("vol_busy_fall", busy, 1'b0);
        check("vol_last_r2", word_q[word_q.size()-2], 24'h3404FC);
        check("vol_last_r3", word_q[word_q.size()-1], 24'h3406FC);

        // two vol_up pulses during an R4 transaction coalesce into one R2/R3 pair
        word_q.delete();
        sel_mic = 1'b0;
        n = 0;
        while (i2c_go !== 1'b1 && n < 20) begin tick(); n++; end
        check("coal_go", i2c_go, 1'b1);
        vol_up = 1'b1;
        tick();
        vol_up = 1'b0;
        check("coal_vol_wrap", volume, 7'h30);
        tick();
        vol_up = 1'b1;
        tick();
        vol_up = 1'b0;
        check("coal_vol_34", volume, 7'h34);
        n = 0;
        while (busy !== 1'b0 && n < 500) begin tick(); n++; end
        check("coal_busy_fall", busy, 1'b0);
        check("coal_count", word_q.size(), 3);
        check("coal_w0", word_q[0], 24'h340812);
        check("coal_w1", word_q[1], 24'h3404B4);
        check("coal_w2", word_q[2], 24'h3406B4);

        // synchronised mic change and vol_up land in the same cycle
        word_q.delete();
        sel_mic = 1'b1;
        tick();
        tick();
        vol_up = 1'b1;
        tick();
        vol_up = 1'b0;
        n = 0;
        while (busy !== 1'b0 && n < 500) begin tick(); n++; end
        check("both_busy_fall", busy, 1'b0);
        check("both_count", word_q.size(), 3);
        check("both_w0", word_q[0], 24'h340814);
        check("both_w1", word_q[1], 24'h3404B8);
        check("both_w2", word_q[2], 24'h3406B8);
        check("both_volume", volume, 7'h38);

        // reset in the middle of the index-5 transaction
        reset = 1'b1;
        tick();
        word_q.delete();
        rise_q.delete();
        reset = 1'b0;
        n = 0;
        while (!(word_q.size() == 6 && i2c_go === 1'b1) && n < 1000) begin tick(); n++; end
        check("mid_go_seen", i2c_go, 1'b1);
        check("mid_w5", word_q[5], 24'h340A00);
        #2;
        reset = 1'b1;
        #1;
        check("mid_go_async_drop", i2c_go, 1'b0);
        check("mid_volume", volume, 7'h79);
        check("mid_data", i2c_data, 24'h0);
        tick();
        word_q.delete();
        rise_q.delete();
        reset = 1'b0;
        n = 0;
        while (cfg_done !== 1'b1 && n < 2000) begin tick(); n++; end
        check("restart_cfg_done", cfg_done, 1'b1);
        check("restart_count", word_q.size(), 10);
        check("restart_w0", word_q[0], 24'h340017);
        check("restart_w4", word_q[4], 24'h340814);
        check("restart_busy", busy, 1'b0);

        // no ack ever: four attempts of word 0 then error
        reset = 1'b1;
        ack_en = 1'b0;
        tick();
        word_q.delete();
        rise_q.delete();
        reset = 1'b0;
        n = 0;
        while (error !== 1'b1 && n < 20000) begin tick(); n++; end
        check("to_error", error, 1'b1);
        check("to_go", i2c_go, 1'b0);
        check("to_busy", busy, 1'b1);
        check("to_cfg_done", cfg_done, 1'b0);
        check("to_count", word_q.size(), 4);
        check("to_w0", word_q[0], 24'h340017);
        check("to_w3", word_q[3], 24'h340017);
        check("to_gap1", 32'(rise_q[1] - rise_q[0]), GAP_EXP);
        check("to_gap2", 32'(rise_q[2] - rise_q[1]), GAP_EXP);
        check("to_gap3", 32'(rise_q[3] - rise_q[2]), GAP_EXP);
        for (int i = 0; i < 50; i++) tick();
        check("to_err_sticky", error, 1'b1);
        check("to_no_more_words", word_q.size(), 4);

        check("handshake_go_rise", go_rise_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
